// File: rtl/joy_poll_sched_if.sv
// Joystick scheduler bus: shared pad lines and mux/select controls on one side,
// the atomically published pad states on the other.
interface joy_poll_sched_if;
  logic        en;
  logic [5:0]  n_joy;
  logic        joy_port;
  logic [1:0]  joy_sel;
  logic [11:0] pad_a;
  logic [11:0] pad_b;
  logic [1:0]  type_a;
  logic [1:0]  type_b;
  logic        valid;
  logic        overrun;

  modport master (
    input  en, n_joy,
    output joy_port, joy_sel, pad_a, pad_b, type_a, type_b, valid, overrun
  );

  modport slave (
    output en, n_joy,
    input  joy_port, joy_sel, pad_a, pad_b, type_a, type_b, valid, overrun
  );
endinterface

// File: rtl/joy_poll_sched.sv
// Polling scheduler for two DB9 pads sharing six lines through an external 2:1 mux.
// Drives the per-port TH sequence, decodes 2/3/6-button pads and publishes both atomically.
module joy_poll_sched #(
  parameter int unsigned StepCycles   = 126,
  parameter int unsigned SampleOffset = 63,
  parameter int unsigned PollCycles   = 224000
) (
  input  logic             clk28,
  input  logic             rst_n,
  joy_poll_sched_if.master bus
);

  localparam int unsigned StepW = $clog2(StepCycles);
  localparam int unsigned PollW = $clog2(PollCycles);
  localparam logic [StepW-1:0] StepLast = StepW'(StepCycles - 1);
  localparam logic [StepW-1:0] SampleAt = StepW'(SampleOffset);
  localparam logic [PollW-1:0] PollLoad = PollW'(PollCycles - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSeq, StPublish} state_e;

  state_e            state_q, state_d;
  logic [5:0]        n_joy_meta_q, n_joy_sync_q;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [StepW-1:0]  step_cnt_q, step_cnt_d;
  logic [2:0]        k_q, k_d;
  logic              port_q, port_d;
  logic [11:0]       shadow_q [2];
  logic [11:0]       shadow_d;
  logic [1:0]        md_q, md6_q;
  logic              md_d, md6_d;
  logic [11:0]       pad_a_q, pad_b_q;
  logic [1:0]        type_a_q, type_b_q;
  logic              valid_q, overrun_q;
  logic              tick, step_last, sample;

  assign tick       = (poll_cnt_q == '0);
  assign step_last  = (step_cnt_q == StepLast);
  assign sample     = (state_q == StSeq) && (step_cnt_q == SampleAt);
  assign poll_cnt_d = tick ? PollLoad : poll_cnt_q - 1'b1;

  always_comb begin
    step_cnt_d = '0;
    if ((state_q == StSettle || state_q == StSeq) && !step_last) begin
      step_cnt_d = step_cnt_q + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      port_q     <= 1'b0;
      step_cnt_q <= '0;
      poll_cnt_q <= PollLoad;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      port_q     <= port_d;
      step_cnt_q <= step_cnt_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  // FSM: next state; en only matters when a poll would start
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    port_d  = port_q;
    unique case (state_q)
      StIdle: begin
        if (tick && bus.en) begin
          state_d = StSettle;
          port_d  = 1'b0;
        end
      end
      StSettle: begin
        if (step_last) begin
          state_d = StSeq;
          k_d     = '0;
        end
      end
      StSeq: begin
        if (step_last) begin
          if (k_q == 3'd7) begin
            if (!port_q) begin
              port_d  = 1'b1;
              state_d = StSettle;
            end else begin
              state_d = StPublish;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StPublish: begin
        state_d = StIdle;
        port_d  = 1'b0;
      end
    endcase
  end

  // FSM: outputs; the mux only moves while both TH lines are low
  always_comb begin
    bus.joy_port = 1'b0;
    bus.joy_sel  = 2'b00;
    if (state_q == StSettle || state_q == StSeq) begin
      bus.joy_port = port_q;
    end
    if (state_q == StSeq) begin
      bus.joy_sel[port_q] = k_q[0];
    end
  end

  // Decode of the sampled lines {b2,b1,right,left,down,up} into the current port's shadow
  always_comb begin
    shadow_d = shadow_q[port_q];
    md_d     = md_q[port_q];
    md6_d    = md6_q[port_q];
    unique case (k_q)
      3'd2: begin
        md_d         = ~n_joy_sync_q[2] & ~n_joy_sync_q[3];
        shadow_d[6]  = md_d & ~n_joy_sync_q[4];
        shadow_d[10] = md_d & ~n_joy_sync_q[5];
      end
      3'd3: shadow_d[5:0] = ~n_joy_sync_q;
      3'd4: md6_d = md_q[port_q] & ~n_joy_sync_q[0] & ~n_joy_sync_q[1];
      3'd5: begin
        shadow_d[11] = md6_q[port_q] & ~n_joy_sync_q[3];
        shadow_d[7]  = md6_q[port_q] & ~n_joy_sync_q[2];
        shadow_d[8]  = md6_q[port_q] & ~n_joy_sync_q[1];
        shadow_d[9]  = md6_q[port_q] & ~n_joy_sync_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      n_joy_meta_q <= '1;
      n_joy_sync_q <= '1;
      shadow_q     <= '{default: '0};
      md_q         <= '0;
      md6_q        <= '0;
    end else begin
      n_joy_meta_q <= bus.n_joy;
      n_joy_sync_q <= n_joy_meta_q;
      if (sample) begin
        shadow_q[port_q] <= shadow_d;
        md_q[port_q]     <= md_d;
        md6_q[port_q]    <= md6_d;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pad_a_q   <= '0;
      pad_b_q   <= '0;
      type_a_q  <= '0;
      type_b_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= (state_q == StPublish);
      overrun_q <= tick && (state_q != StIdle);
      if (state_q == StPublish) begin
        pad_a_q  <= shadow_q[0];
        pad_b_q  <= shadow_q[1];
        type_a_q <= md6_q[0] ? 2'd2 : {1'b0, md_q[0]};
        type_b_q <= md6_q[1] ? 2'd2 : {1'b0, md_q[1]};
      end
    end
  end

  assign bus.pad_a   = pad_a_q;
  assign bus.pad_b   = pad_b_q;
  assign bus.type_a  = type_a_q;
  assign bus.type_b  = type_b_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_joy_poll_sched.sv
// Bench for joy_poll_sched: behavioural pads on both ports feed a scoreboard of expected
// publishes; a second instance with a short poll period exercises overrun and enable.
module tb_joy_poll_sched;

  localparam int unsigned P1    = 3000;
  localparam int unsigned P2    = 2000;
  localparam int unsigned Lat   = 18 * 126 + 2;
  localparam int          NPoll = 8;

  logic clk28 = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk28 = ~clk28;

  joy_poll_sched_if bus1 ();
  joy_poll_sched_if bus2 ();

  joy_poll_sched #(.StepCycles(126), .SampleOffset(63), .PollCycles(P1)) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  joy_poll_sched #(.StepCycles(126), .SampleOffset(63), .PollCycles(P2)) dut2 (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // pad type: 0 none, 1 Atari 2-button, 2 MD 3-button, 3 MD 6-button
  // buttons use the published layout: {mode,start,z,y,x,a,c,b,right,left,down,up}
  int          ty [2];
  logic [11:0] btn [2];
  logic [27:0] sb_q [$];

  int  th_r [2];
  int  since [2];
  int  lowc [2];
  bit  th_prev [2];

  int          valid_cnt = 0, valid_cyc = 0, last_valid = 0, ovr1_cnt = 0;
  int          mux_err = 0, stab_err = 0;
  bit          have_prev = 0, chk_period = 0;
  logic        prev_port;
  logic [27:0] prev_pub;
  int          valid2_cnt = 0, valid2_cyc = 0, ovr2_cnt = 0, ovr2_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [13:0] model(input int t, input logic [11:0] b);
    case (t)
      0:       return 14'h0;
      1:       return {2'd0, b & 12'h03f};
      2:       return {2'd1, b & 12'h47f};
      default: return {2'd2, b};
    endcase
  endfunction

  // Raw active-low lines a pad drives for a given TH level and count of TH rising edges
  function automatic logic [5:0] pad_lines(input int t, input logic [11:0] b, input bit th,
                                           input int r);
    if (t == 0) return 6'h3f;
    if (t == 1) return ~b[5:0];
    if (th) begin
      if (t == 3 && r == 3) return ~{b[5], b[4], b[11], b[7], b[8], b[9]};
      return ~b[5:0];
    end
    if (t == 3 && r == 2) return {~b[10], ~b[6], 4'b0000};
    return {~b[10], ~b[6], 2'b00, ~b[1], ~b[0]};
  endfunction

  task automatic set_pads(input int i);
    logic [13:0] ea, eb;
    for (int p = 0; p < 2; p++) begin
      ty[p]  = int'($urandom_range(0, 3));
      btn[p] = 12'($urandom);
    end
    if (i == 0) begin
      ty[0] = 0; ty[1] = 0;
    end else if (i == 1) begin
      ty[0] = 2; btn[0] = 12'h440; ty[1] = 0;
    end else if (i == 2) begin
      ty[0] = 0; ty[1] = 3; btn[1] = 12'h890;
    end else if (i == NPoll - 1) begin
      ty[0] = 3; ty[1] = 3; btn[0] = btn[0] | 12'h010; btn[1] = btn[1] | 12'h020;
    end
    for (int p = 0; p < 2; p++) begin
      if (btn[p][0]) btn[p][1] = 1'b0;
      if (btn[p][2]) btn[p][3] = 1'b0;
    end
    ea = model(ty[0], btn[0]);
    eb = model(ty[1], btn[1]);
    sb_q.push_back({ea[11:0], eb[11:0], ea[13:12], eb[13:12]});
  endtask

  initial forever begin
    @(posedge clk28);
    cyc++;
  end

  // Pad model: lines are only trustworthy 30..100 cycles after a TH edge, garbage otherwise
  initial forever begin
    @(negedge clk28);
    for (int p = 0; p < 2; p++) begin
      if (bus1.joy_sel[p] != th_prev[p]) since[p] = 0;
      else if (since[p] < 1000) since[p]++;
      if (bus1.joy_sel[p] && !th_prev[p]) th_r[p]++;
      else if (lowc[p] > 500) th_r[p] = 0;
      if (bus1.joy_sel[p]) lowc[p] = 0;
      else if (lowc[p] < 1000) lowc[p]++;
      th_prev[p] = bus1.joy_sel[p];
    end
    if (bus1.joy_port === 1'b1) begin
      if (since[1] >= 30 && since[1] <= 100)
        bus1.n_joy = pad_lines(ty[1], btn[1], bus1.joy_sel[1], th_r[1]);
      else
        bus1.n_joy = 6'($urandom);
    end else begin
      if (since[0] >= 30 && since[0] <= 100)
        bus1.n_joy = pad_lines(ty[0], btn[0], bus1.joy_sel[0], th_r[0]);
      else
        bus1.n_joy = 6'($urandom);
    end
  end

  // Monitor for the main instance: scoreboard pop on valid plus mux and stability rules
  initial forever begin
    logic [27:0] got;
    @(negedge clk28);
    if (rst_n === 1'b1) begin
      got = {bus1.pad_a, bus1.pad_b, bus1.type_a, bus1.type_b};
      if (bus1.valid) begin
        valid_cnt++;
        valid_cyc = cyc;
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) chk("publish", got, sb_q.pop_front());
        if (chk_period) chk("poll_period", cyc - last_valid, P1);
        chk_period = 1;
        last_valid = cyc;
      end else if (have_prev && got != prev_pub) begin
        stab_err++;
      end
      if (have_prev && bus1.joy_port != prev_port && bus1.joy_sel != 2'b00) mux_err++;
      if ((bus1.joy_sel[1] && !bus1.joy_port) || (bus1.joy_sel[0] && bus1.joy_port)) mux_err++;
      if (bus1.overrun) ovr1_cnt++;
      prev_pub  = got;
      prev_port = bus1.joy_port;
      have_prev = 1;
    end else begin
      have_prev  = 0;
      chk_period = 0;
    end
  end

  initial forever begin
    @(negedge clk28);
    if (rst_n === 1'b1) begin
      if (bus2.valid) begin
        valid2_cnt++;
        valid2_cyc = cyc;
      end
      if (bus2.overrun) begin
        ovr2_cnt++;
        ovr2_cyc = cyc;
      end
    end
  end

  task automatic wait_valid1(input int bound, input string name);
    int c0 = valid_cnt;
    int n  = 0;
    while (valid_cnt == c0 && n < bound) begin
      @(negedge clk28);
      n++;
    end
    chk(name, valid_cnt != c0, 1);
  endtask

  task automatic wait_valid2(input int bound, input string name);
    int c0 = valid2_cnt;
    int n  = 0;
    while (valid2_cnt == c0 && n < bound) begin
      @(negedge clk28);
      n++;
    end
    chk(name, valid2_cnt != c0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got cycle %0d, required finish before 90000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, v1, o0, v2, o2, n, rel;
    bus1.en = 1'b1;
    bus2.en = 1'b1;
    bus2.n_joy = 6'h3f;
    set_pads(0);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk28);
    chk("reset_state", {bus1.pad_a, bus1.pad_b, bus1.type_a, bus1.type_b, bus1.valid,
                        bus1.overrun, bus1.joy_sel, bus1.joy_port}, 0);
    rst_n = 1'b1;

    fork
      begin
        for (int i = 0; i < NPoll; i++) begin
          if (i > 0) set_pads(i);
          wait_valid1(7000, "main_valid");
        end
      end
      begin
        wait_valid2(6000, "ovr_first_valid");
        v0 = valid2_cyc;
        o0 = ovr2_cnt;
        wait_valid2(4500, "ovr_second_valid");
        v1 = valid2_cyc;
        chk("ovr_no_restart", v1 - v0, 2 * P2);
        chk("ovr_pulse_count", ovr2_cnt - o0, 1);
        chk("ovr_in_poll", (ovr2_cyc > v1 - Lat) && (ovr2_cyc < v1), 1);
        while (cyc < v1 - Lat + 2 * P2 + 300) @(negedge clk28);
        chk("en_off_at_k1", bus2.joy_sel, 2'b01);
        bus2.en = 1'b0;
        wait_valid2(2500, "en_off_publish");
        chk("en_off_latency", valid2_cyc - v1, 2 * P2);
        v2 = valid2_cnt;
        o2 = ovr2_cnt;
        repeat (10000) @(negedge clk28);
        chk("en_off_no_poll", valid2_cnt - v2, 0);
        chk("en_off_no_ovr", ovr2_cnt - o2, 0);
        bus2.en = 1'b1;
        wait_valid2(P2 + Lat + 10, "en_resume");
      end
    join

    // Reset in the middle of port A's k=3 step
    n = 0;
    while (!(th_r[0] == 2 && bus1.joy_sel[0] && !bus1.joy_port) && n < 5000) begin
      @(negedge clk28);
      n++;
    end
    chk("reach_k3", n < 5000, 1);
    repeat (10) @(negedge clk28);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sel", bus1.joy_sel, 2'b00);
    chk("rst_port", bus1.joy_port, 1'b0);
    chk("rst_outputs", {bus1.pad_a, bus1.pad_b, bus1.type_a, bus1.type_b}, 0);
    @(negedge clk28);
    rst_n = 1'b1;
    rel = cyc;
    set_pads(NPoll);
    wait_valid1(P1 + Lat + 100, "post_reset_valid");
    chk("post_reset_latency",
        (valid_cyc - rel >= P1 + Lat - 2) && (valid_cyc - rel <= P1 + Lat), 1);

    chk("mux_rules", mux_err, 0);
    chk("pub_stable", stab_err, 0);
    chk("main_no_overrun", ovr1_cnt, 0);
    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/joy_poll_sched.md
Name: joy_poll_sched

Overview:
Polling scheduler for two DB9 Sega/Atari joystick ports that share one set of six input lines through an external 2:1 mux. It owns the poll timer, the per-port select (TH) toggle sequence, the mux control and the sampling instants. It decodes 2/3/6-button pads and publishes both pads' states atomically to the port-read logic. It runs from a free-running cycle timer, with no dependency on video counters.

Parameters:
STEP_CYCLES, 126, clk28 cycles per select step (~4.5 us).
SAMPLE_OFFSET, 63, cycle within a step at which the lines are sampled (must be < STEP_CYCLES).
POLL_CYCLES, 224000, cycles between poll starts (~8 ms).

Ports:
clk28  in  1  system clock
rst_n  in  1  async active-low reset
en  in  1  polling enable
n_joy  in  6  shared raw lines {b2,b1,right,left,down,up}, active low, asynchronous
joy_port  out  1  external mux select: 0 = port A, 1 = port B
joy_sel  out  2  TH select per port, [0] = A, [1] = B
pad_a  out  12  {mode,start,z,y,x,b3,b2,b1,right,left,down,up}, active high
pad_b  out  12  same layout for port B
type_a  out  2  0 = 2-button/none, 1 = 3-button MD, 2 = 6-button MD
type_b  out  2  same for port B
valid  out  1  one-cycle pulse when pad_*/type_* update
overrun  out  1  one-cycle pulse when a poll tick is dropped

Behaviour:
- Reset: all outputs 0; FSM in IDLE; poll timer reloads to POLL_CYCLES-1; step counter 0.
- Input sync: n_joy passes through a 2-flop synchronizer. All decoding uses synced values.
- Poll timer: free-running down-counter. It reloads on reaching 0 and generates a tick on that cycle. The timer runs regardless of en.
- FSM states: IDLE, SETTLE, SEQ, PUBLISH.
- IDLE: on tick with en=1, go to SETTLE with port=0 and joy_port=0.
- SETTLE: lasts one step (STEP_CYCLES cycles). Both joy_sel bits are held 0. Then go to SEQ with step index k=0.
- SEQ: 8 steps, k = 0..7, each STEP_CYCLES cycles.
  - joy_sel[port] = k[0] during the step; the other bit stays 0.
  - Lines are sampled at cycle SAMPLE_OFFSET of the step into the shadow set for the current port:
  - k=2: if left=0 and right=0, then md=1, b3=~b1, start=~b2. Otherwise md=0, b3=0, start=0.
  - k=3: up, down, left, right, b1, b2 captured inverted.
  - k=4: md6 = md and up=0 and down=0.
  - k=5: if md6, then mode=~right, x=~left, y=~down, z=~up. Otherwise all four are 0.
  - After k=7: if port=0, set port=1, joy_port=1, and return to SETTLE. If port=1, go to PUBLISH.
- PUBLISH: lasts 1 cycle.
  - Shadow sets copy to pad_a/pad_b and type_a/type_b in the same cycle. Type = md6 ? 2 : md ? 1 : 0.
  - valid pulses on the next cycle, coinciding with the first cycle of new outputs.
  - Set joy_port=0, joy_sel=00, then go to IDLE.
- Latency: tick to valid = 18*STEP_CYCLES + 2 cycles (2270 at defaults).
- joy_port changes only while joy_sel=00, never within a SEQ step.
- Tick arriving while not in IDLE: tick is ignored and overrun pulses 1 cycle; the FSM is undisturbed.
- Tick with en=0 in IDLE: stays IDLE, no overrun.
- en deasserted mid-poll: the current poll completes and publishes normally; en is sampled only in IDLE.
- Published outputs never change except in PUBLISH. Partial or aborted polls are never visible.
- Reset mid-poll: returns to reset state immediately; joy_sel=00 and joy_port=0 asynchronously.
- Counter widths are sized by $clog2 of the respective parameters; no wrap beyond parameter values.

Test Plan:
- Reset mid-SEQ (assert rst_n=0 at k=3) -> joy_sel=00, joy_port=0, pad_a/pad_b=0, type_*=0 immediately. After release, first valid occurs POLL_CYCLES+2270 cycles later.
- No pads (n_joy all 1 on both ports) -> pad_a=pad_b=12'h000, type_a=type_b=0, valid once per 224000 cycles, overrun never pulses.
- 3-button model on port A (left/right low on k=2), A and Start held -> pad_a[6]=1 (b3), pad_a[10]=1 (start), type_a=1, pad_a[11:7] bits z/y/x/mode all 0.
- 6-button model on port B, X and Mode held, B held -> type_b=2, pad_b[7]=1 (x), pad_b[11]=1 (mode), pad_b[4]=1 (b1). Port A unaffected.
- Mux timing checker over 10 polls -> joy_port toggles only when joy_sel=00. joy_sel[1] is never 1 while joy_port=0. Sample instants fall exactly at cycle 63 of each step.
- POLL_CYCLES=2000 (shorter than 2270) -> a tick during a poll produces an overrun pulse and no restart. Plus: en=0 asserted at k=1 of port A -> that poll still publishes (valid=1), no further polls until en=1.
